// File: rtl/cipher_drv_pkg.sv
// Shared definitions for the cipher stream driver.
//   drv_state_e : driver FSM state encoding
//   nb_w()      : width of a per-block byte-count field for a given block width
//   calc_nblk() : number of blocks in a message (an empty message still has one)
//   blk_nbytes(): valid bytes in the block whose remaining-block count is cnt
package cipher_drv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MASK,
        ST_START,
        ST_STREAM,
        ST_DRAIN
    } drv_state_e;

    function automatic int unsigned nb_w(input int unsigned blk_size);
        return $clog2(blk_size / 8) + 1;
    endfunction

    function automatic int unsigned calc_nblk(input int unsigned len, input int unsigned bpb);
        return (len == 0) ? 1 : (len + bpb - 1) / bpb;
    endfunction

    // cnt counts down, so cnt == 1 marks the final block of the message.
    function automatic int unsigned blk_nbytes(input int unsigned len, input int unsigned nblk,
                                               input int unsigned cnt, input int unsigned bpb);
        if (len == 0) begin
            return 0;
        end
        if (cnt == 1) begin
            return len - (nblk - 1) * bpb;
        end
        return bpb;
    endfunction

endpackage

// File: rtl/msk_share_gen.sv
// Combinational Boolean masking of a key into D shares.
//   key    : unmasked key
//   rnd    : D-1 fresh random slices, slice i-1 at [(i-1)*WIDTH +: WIDTH]
//   shares : share-major output; shares 1..D-1 are the random slices,
//            share 0 is key XOR all slices, so the XOR of all shares is the key
module msk_share_gen #(
    parameter int unsigned D     = 2,
    parameter int unsigned WIDTH = 128
) (
    input  logic [WIDTH-1:0]       key,
    input  logic [WIDTH*(D-1)-1:0] rnd,
    output logic [WIDTH*D-1:0]     shares
);

    logic [WIDTH-1:0] acc;

    always_comb begin
        shares = '0;
        acc    = key;
        for (int unsigned i = 1; i < D; i++) begin
            shares[i*WIDTH +: WIDTH] = rnd[(i-1)*WIDTH +: WIDTH];
            acc                      = acc ^ rnd[(i-1)*WIDTH +: WIDTH];
        end
        shares[0 +: WIDTH] = acc;
    end

endmodule

// File: rtl/cipher_stream_driver.sv
// Drives a masked AEAD-style cipher core with one job at a time.
//   job_*   : job request (key, nonce, byte length); accepted only in IDLE
//   rnd*    : fresh randomness used to split the key into D shares
//   pt_*    : plaintext block stream from the host
//   c_*     : cipher-core side (start pulse, masked key, nonce, pt out, ct in, tag, busy)
//   ct_*    : ciphertext stream to the host (combinational pass-through)
//   tag     : tag captured when the core drops busy after the last block
//   done    : one-cycle pulse on successful completion
//   err     : one-cycle pulse when the inactivity watchdog expires
module cipher_stream_driver
    import cipher_drv_pkg::*;
#(
    parameter int unsigned D          = 2,
    parameter int unsigned KEY_SIZE   = 128,
    parameter int unsigned NONCE_SIZE = 128,
    parameter int unsigned BLK_SIZE   = 64,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned TIMEOUT    = 1024,
    localparam int unsigned NB_W      = nb_w(BLK_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [KEY_SIZE-1:0]         job_key,
    input  logic [NONCE_SIZE-1:0]       job_nonce,
    input  logic [LEN_W-1:0]            job_len,

    input  logic                        rnd_valid,
    input  logic [KEY_SIZE*(D-1)-1:0]   rnd,

    input  logic                        pt_valid,
    output logic                        pt_ready,
    input  logic [BLK_SIZE-1:0]         pt_data,

    output logic                        c_start,
    output logic [KEY_SIZE*D-1:0]       c_key,
    output logic [NONCE_SIZE-1:0]       c_nonce,
    output logic [BLK_SIZE-1:0]         c_pt,
    output logic [NB_W-1:0]             c_pt_nbytes,
    output logic                        c_pt_valid,
    input  logic                        c_pt_ready,
    input  logic [BLK_SIZE-1:0]         c_ct,
    input  logic                        c_ct_valid,
    output logic                        c_ct_ready,
    output logic                        c_ct_last,
    input  logic [127:0]                c_tag,
    input  logic                        c_busy,

    output logic                        ct_valid,
    input  logic                        ct_ready,
    output logic [BLK_SIZE-1:0]         ct_data,
    output logic [NB_W-1:0]             ct_nbytes,
    output logic                        ct_last,
    output logic [127:0]                tag,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned BPB      = BLK_SIZE / 8;
    localparam int unsigned WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

    drv_state_e                 state_q, state_d;
    logic [KEY_SIZE-1:0]        key_q, key_d;
    logic [NONCE_SIZE-1:0]      nonce_q, nonce_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [LEN_W-1:0]           nblk_q, nblk_d;
    logic [LEN_W-1:0]           in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0]           out_cnt_q, out_cnt_d;
    logic [KEY_SIZE*D-1:0]      shares_q, shares_d;
    logic [127:0]               tag_q, tag_d;
    logic                       busy_q, busy_d;
    logic [WD_W-1:0]            wd_q, wd_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic [KEY_SIZE*D-1:0]      gen_shares;
    logic                       in_act;
    logic                       out_act;
    logic                       pt_hs;
    logic                       ct_hs;
    logic                       rnd_hs;
    logic                       busy_fall;
    logic                       wd_clear;
    logic [LEN_W-1:0]           job_nblk;

    msk_share_gen #(
        .D     (D),
        .WIDTH (KEY_SIZE)
    ) u_share_gen (
        .key    (key_q),
        .rnd    (rnd),
        .shares (gen_shares)
    );

    // Both directions are gated by their own block count so the host can
    // never push or pull past the end of the message.
    assign in_act  = (state_q == ST_STREAM) && (in_cnt_q != '0);
    assign out_act = (state_q == ST_STREAM) && (out_cnt_q != '0);

    assign job_ready   = (state_q == ST_IDLE);
    assign c_start     = (state_q == ST_START);
    assign c_key       = shares_q;
    assign c_nonce     = nonce_q;

    assign c_pt        = in_act ? pt_data : '0;
    assign c_pt_valid  = in_act & pt_valid;
    assign pt_ready    = in_act & c_pt_ready;
    assign c_pt_nbytes = in_act
                       ? NB_W'(blk_nbytes(32'(len_q), 32'(nblk_q), 32'(in_cnt_q), BPB))
                       : '0;

    assign ct_valid    = out_act & c_ct_valid;
    assign ct_data     = out_act ? c_ct : '0;
    assign c_ct_ready  = out_act & ct_ready;
    assign ct_nbytes   = out_act
                       ? NB_W'(blk_nbytes(32'(len_q), 32'(nblk_q), 32'(out_cnt_q), BPB))
                       : '0;
    assign ct_last     = out_act && (out_cnt_q == LEN_W'(1));
    assign c_ct_last   = ct_last;

    assign tag  = tag_q;
    assign done = done_q;
    assign err  = err_q;

    assign pt_hs     = c_pt_valid & c_pt_ready;
    assign ct_hs     = c_ct_valid & c_ct_ready;
    assign rnd_hs    = (state_q == ST_MASK) & rnd_valid;
    assign busy_fall = busy_q & ~c_busy;
    assign wd_clear  = rnd_hs | pt_hs | ct_hs | busy_fall;
    assign job_nblk  = LEN_W'(calc_nblk(32'(job_len), BPB));

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        nonce_d   = nonce_q;
        len_d     = len_q;
        nblk_d    = nblk_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        shares_d  = shares_q;
        tag_d     = tag_q;
        busy_d    = c_busy;
        wd_d      = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    key_d     = job_key;
                    nonce_d   = job_nonce;
                    len_d     = job_len;
                    nblk_d    = job_nblk;
                    in_cnt_d  = job_nblk;
                    out_cnt_d = job_nblk;
                    state_d   = ST_MASK;
                end
            end
            ST_MASK: begin
                if (rnd_valid) begin
                    shares_d = gen_shares;
                    // The plain key is no longer needed once it is split.
                    key_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (pt_hs) begin
                    in_cnt_d = in_cnt_q - LEN_W'(1);
                end
                if (ct_hs) begin
                    out_cnt_d = out_cnt_q - LEN_W'(1);
                    if (out_cnt_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (busy_fall) begin
                    tag_d    = c_tag;
                    done_d   = 1'b1;
                    shares_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Watchdog overrides whatever the state logic chose this cycle; a
        // cycle with any progress (including the busy fall) can never expire.
        if (state_q != ST_IDLE) begin
            if (wd_clear) begin
                wd_d = '0;
            end else if (wd_q == WD_LIMIT) begin
                err_d    = 1'b1;
                done_d   = 1'b0;
                shares_d = '0;
                key_d    = '0;
                state_d  = ST_IDLE;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            key_q     <= '0;
            nonce_q   <= '0;
            len_q     <= '0;
            nblk_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            shares_q  <= '0;
            tag_q     <= '0;
            busy_q    <= 1'b0;
            wd_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            nonce_q   <= nonce_d;
            len_q     <= len_d;
            nblk_q    <= nblk_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            shares_q  <= shares_d;
            tag_q     <= tag_d;
            busy_q    <= busy_d;
            wd_q      <= wd_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_cipher_stream_driver.sv
module tb_cipher_stream_driver;

    localparam int TO = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // D=2, BLK_SIZE=64 instance
    logic         job_valid, job_ready;
    logic [127:0] job_key, job_nonce;
    logic [15:0]  job_len;
    logic         rnd_valid;
    logic [127:0] rnd;
    logic         pt_valid, pt_ready;
    logic [63:0]  pt_data;
    logic         c_start;
    logic [255:0] c_key;
    logic [127:0] c_nonce;
    logic [63:0]  c_pt;
    logic [3:0]   c_pt_nbytes;
    logic         c_pt_valid, c_pt_ready;
    logic [63:0]  c_ct;
    logic         c_ct_valid, c_ct_ready, c_ct_last;
    logic [127:0] c_tag;
    logic         c_busy;
    logic         ct_valid, ct_ready;
    logic [63:0]  ct_data;
    logic [3:0]   ct_nbytes;
    logic         ct_last;
    logic [127:0] tag;
    logic         done, err;

    cipher_stream_driver dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key),
        .job_nonce(job_nonce), .job_len(job_len),
        .rnd_valid(rnd_valid), .rnd(rnd),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .c_start(c_start), .c_key(c_key), .c_nonce(c_nonce), .c_pt(c_pt),
        .c_pt_nbytes(c_pt_nbytes), .c_pt_valid(c_pt_valid), .c_pt_ready(c_pt_ready),
        .c_ct(c_ct), .c_ct_valid(c_ct_valid), .c_ct_ready(c_ct_ready),
        .c_ct_last(c_ct_last), .c_tag(c_tag), .c_busy(c_busy),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .ct_nbytes(ct_nbytes), .ct_last(ct_last), .tag(tag), .done(done), .err(err)
    );

    // D=3, BLK_SIZE=128 instance
    logic         b_job_valid, b_job_ready;
    logic [127:0] b_job_key, b_job_nonce;
    logic [15:0]  b_job_len;
    logic         b_rnd_valid;
    logic [255:0] b_rnd;
    logic         b_pt_valid, b_pt_ready;
    logic [127:0] b_pt_data;
    logic         b_c_start;
    logic [383:0] b_c_key;
    logic [127:0] b_c_nonce;
    logic [127:0] b_c_pt;
    logic [4:0]   b_c_pt_nbytes;
    logic         b_c_pt_valid, b_c_pt_ready;
    logic [127:0] b_c_ct;
    logic         b_c_ct_valid, b_c_ct_ready, b_c_ct_last;
    logic [127:0] b_c_tag;
    logic         b_c_busy;
    logic         b_ct_valid, b_ct_ready;
    logic [127:0] b_ct_data;
    logic [4:0]   b_ct_nbytes;
    logic         b_ct_last;
    logic [127:0] b_tag;
    logic         b_done, b_err;

    cipher_stream_driver #(.D(3), .BLK_SIZE(128)) dut3 (
        .clk(clk), .rst(rst),
        .job_valid(b_job_valid), .job_ready(b_job_ready), .job_key(b_job_key),
        .job_nonce(b_job_nonce), .job_len(b_job_len),
        .rnd_valid(b_rnd_valid), .rnd(b_rnd),
        .pt_valid(b_pt_valid), .pt_ready(b_pt_ready), .pt_data(b_pt_data),
        .c_start(b_c_start), .c_key(b_c_key), .c_nonce(b_c_nonce), .c_pt(b_c_pt),
        .c_pt_nbytes(b_c_pt_nbytes), .c_pt_valid(b_c_pt_valid), .c_pt_ready(b_c_pt_ready),
        .c_ct(b_c_ct), .c_ct_valid(b_c_ct_valid), .c_ct_ready(b_c_ct_ready),
        .c_ct_last(b_c_ct_last), .c_tag(b_c_tag), .c_busy(b_c_busy),
        .ct_valid(b_ct_valid), .ct_ready(b_ct_ready), .ct_data(b_ct_data),
        .ct_nbytes(b_ct_nbytes), .ct_last(b_ct_last), .tag(b_tag), .done(b_done), .err(b_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: per-job list of block byte counts plus expected key shares.
    int           m_nb[$];
    int           m_nblk;
    int           in_idx, out_idx;
    bit           streaming, start_seen, checks_on;
    int           done_cnt, err_cnt;
    logic [255:0] exp_key, last_c_key;
    logic [127:0] exp_nonce, exp_tag;
    int           seen_nb[$];
    bit           seen_last[$];

    task automatic model_job(input int len, input logic [127:0] key, input logic [127:0] r,
                             input logic [127:0] nonce, input logic [127:0] t);
        int remaining;
        int nb;
        m_nb.delete();
        remaining = len;
        if (len == 0) m_nb.push_back(0);
        while (remaining > 0) begin
            nb = (remaining > 8) ? 8 : remaining;
            m_nb.push_back(nb);
            remaining -= nb;
        end
        m_nblk     = m_nb.size();
        exp_key    = {r, key ^ r};
        exp_nonce  = nonce;
        exp_tag    = t;
        in_idx     = 0;
        out_idx    = 0;
        streaming  = 0;
        start_seen = 0;
        done_cnt   = 0;
        err_cnt    = 0;
        seen_nb.delete();
        seen_last.delete();
    endtask

    always @(negedge clk) begin
        if (rst && checks_on) begin
            if (c_start) begin
                start_seen = 1;
                last_c_key = c_key;
                chk("c_key", c_key, exp_key);
                chk("c_nonce", c_nonce, {128'd0, exp_nonce});
                streaming = 1;
            end else begin
                chk("c_pt_valid", c_pt_valid, pt_valid && streaming && in_idx < m_nblk);
                chk("pt_ready", pt_ready, c_pt_ready && streaming && in_idx < m_nblk);
                if (c_pt_valid && in_idx < m_nblk) begin
                    chk("c_pt_nbytes", c_pt_nbytes, m_nb[in_idx]);
                    chk("c_pt", c_pt, pt_data);
                    if (c_pt_ready) in_idx++;
                end
                chk("ct_valid", ct_valid, c_ct_valid && streaming && out_idx < m_nblk);
                chk("c_ct_ready", c_ct_ready, ct_ready && streaming && out_idx < m_nblk);
                if (ct_valid && out_idx < m_nblk) begin
                    chk("ct_nbytes", ct_nbytes, m_nb[out_idx]);
                    chk("ct_last", ct_last, out_idx == m_nblk - 1);
                    chk("c_ct_last", c_ct_last, out_idx == m_nblk - 1);
                    chk("ct_data", ct_data, c_ct);
                    if (ct_ready) begin
                        seen_nb.push_back(int'(ct_nbytes));
                        seen_last.push_back(ct_last);
                        out_idx++;
                        if (out_idx == m_nblk) streaming = 0;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                chk("tag at done", tag, exp_tag);
            end
            if (err) err_cnt++;
        end
    end

    task automatic accept_job(input logic [127:0] key, input logic [127:0] nonce, input int len);
        @(posedge clk); #1;
        job_valid = 1; job_key = key; job_nonce = nonce; job_len = 16'(len);
        @(posedge clk); #1;
        job_valid = 0;
    endtask

    task automatic run_job(input logic [127:0] key, input logic [127:0] r, input logic [127:0] nonce,
                           input logic [127:0] t, input int len, input int stall_at,
                           input int stall_len, input int abort_cyc);
        int pi, ci, cyc, n;
        bit pt_hs, ct_hs;
        model_job(len, key, r, nonce, t);
        accept_job(key, nonce, len);
        rnd_valid = 1; rnd = r;
        @(posedge clk); #1;
        rnd_valid = 0;
        n = 0;
        while (!start_seen && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("c_start seen", start_seen, 1);
        c_busy = 1;
        pi = 0; ci = 0; cyc = 0;
        while (ci < m_nblk && cyc < 600) begin
            pt_valid   = (pi < m_nblk);
            pt_data    = 64'h5A5A_0000_0000_0000 + 64'(pi);
            c_pt_ready = 1;
            c_ct_valid = (ci < pi);
            c_ct       = 64'hC3C3_0000_0000_0000 + 64'(ci);
            ct_ready   = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (cyc == abort_cyc) begin
                #2;
                checks_on = 0;
                rst = 0;
                #1;
                chk("rst c_key", c_key, '0);
                chk("rst c_nonce", c_nonce, '0);
                chk("rst tag", tag, '0);
                chk("rst strobes", {c_start, c_pt_valid, pt_ready, ct_valid, ct_last,
                                    c_ct_last, c_ct_ready, done, err}, '0);
                chk("rst nbytes", {c_pt_nbytes, ct_nbytes}, '0);
                chk("rst job_ready", job_ready, 1);
                pt_valid = 0; c_pt_ready = 0; c_ct_valid = 0; ct_ready = 0; c_busy = 0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1;
                streaming = 0;
                checks_on = 1;
                return;
            end
            @(negedge clk);
            pt_hs = pt_valid && pt_ready;
            ct_hs = ct_valid && ct_ready;
            @(posedge clk); #1;
            pi += int'(pt_hs);
            ci += int'(ct_hs);
            cyc++;
        end
        chk("blocks out", ci, m_nblk);
        pt_valid = 0; c_ct_valid = 0; c_pt_ready = 0; ct_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        c_tag = t; c_busy = 0;
        n = 0;
        while (done_cnt == 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("job_ready after done", job_ready, 1);
        chk("shares zeroed", c_key, '0);
        c_tag = ~t;
        @(posedge clk); #1;
        chk("done pulses", done_cnt, 1);
        chk("done one cycle", done, 0);
        chk("no err", err_cnt, 0);
        chk("tag holds", tag, t);
    endtask

    task automatic timeout_job();
        int n;
        model_job(16, 128'h1111, 128'h2222, 128'h3333, 128'h0);
        accept_job(128'h1111, 128'h3333, 16);
        n = 0;
        while (!err && n < 1100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("watchdog cycles", n, TO);
        chk("timeout no start", start_seen, 0);
        chk("timeout shares", c_key, '0);
        chk("timeout job_ready", job_ready, 1);
        @(posedge clk); #1;
        chk("err one cycle", err, 0);
        chk("err pulses", err_cnt, 1);
        chk("timeout no done", done_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    logic [127:0] k1;
    logic [127:0] x3;
    int           nb0, nb1;

    initial begin
        job_valid = 0; job_key = '0; job_nonce = '0; job_len = '0;
        rnd_valid = 0; rnd = '0; pt_valid = 0; pt_data = '0;
        c_pt_ready = 0; c_ct = '0; c_ct_valid = 0; c_tag = '0; c_busy = 0; ct_ready = 0;
        b_job_valid = 0; b_job_key = '0; b_job_nonce = '0; b_job_len = '0;
        b_rnd_valid = 0; b_rnd = '0; b_pt_valid = 0; b_pt_data = '0;
        b_c_pt_ready = 0; b_c_ct = '0; b_c_ct_valid = 0; b_c_tag = '0; b_c_busy = 0; b_ct_ready = 0;
        checks_on = 0;

        #12;
        chk("reset job_ready", job_ready, 1);
        chk("reset c_key", c_key, '0);
        chk("reset tag", tag, '0);
        chk("reset done/err/start", {done, err, c_start}, '0);
        @(negedge clk);
        rst = 1;
        checks_on = 1;

        k1 = 128'h544480d81a2483237c795768a7444ec3;
        run_job(k1, '1, 128'hA5A5_0001, 128'hDEAD_0001, 16, -1, 0, -1);
        chk("share0 literal", last_c_key[127:0], 128'habbb7f27e5db7cdc8386a89758bbb13c);
        chk("share1 literal", last_c_key[255:128], 128'hffffffffffffffffffffffffffffffff);
        nb0 = seen_nb.size() > 0 ? seen_nb[0] : -1;
        nb1 = seen_nb.size() > 1 ? seen_nb[1] : -1;
        chk("len16 nbytes", {seen_nb.size(), nb0, nb1}, {32'd2, 32'd8, 32'd8});
        chk("len16 last flags", {seen_last.size() > 1 ? seen_last[1] : 1'b0,
                                 seen_last.size() > 0 ? seen_last[0] : 1'b1}, 2'b10);

        run_job(128'h0F0F, 128'h1234_5678, 128'hA5A5_0002, 128'hDEAD_0002, 13, -1, 0, -1);
        nb0 = seen_nb.size() > 0 ? seen_nb[0] : -1;
        nb1 = seen_nb.size() > 1 ? seen_nb[1] : -1;
        chk("len13 nbytes", {seen_nb.size(), nb0, nb1}, {32'd2, 32'd8, 32'd5});

        run_job(128'hBEEF, 128'h5555, 128'hA5A5_0003, 128'hDEAD_0003, 0, -1, 0, -1);
        nb0 = seen_nb.size() > 0 ? seen_nb[0] : -1;
        chk("len0 nbytes", {seen_nb.size(), nb0}, {32'd1, 32'd0});
        chk("len0 last", seen_last.size() > 0 ? seen_last[0] : 1'b0, 1);

        run_job(128'hCAFE, 128'h9999, 128'hA5A5_0004, 128'hDEAD_0004, 40, 2, 100, -1);
        chk("stall blocks", seen_nb.size(), 5);

        timeout_job();

        run_job(128'h7777, 128'h8888, 128'hA5A5_0006, 128'hDEAD_0006, 32, -1, 0, 3);
        run_job(128'h4242, 128'h2424, 128'hA5A5_0007,
                128'h0123456789abcdeffedcba9876543210, 24, -1, 0, -1);
        chk("tag after reset", tag, 128'h0123456789abcdeffedcba9876543210);

        // D=3, 128-bit blocks
        @(posedge clk); #1;
        b_job_valid = 1; b_job_key = k1; b_job_nonce = 128'h99; b_job_len = 16'd32;
        @(posedge clk); #1;
        b_job_valid = 0; b_rnd_valid = 1;
        b_rnd = {128'h0badf00d_0badf00d_0badf00d_0badf00d, 128'h13579bdf_2468ace0_fedcba98_76543210};
        @(posedge clk); #1;
        b_rnd_valid = 0;
        chk("d3 c_start", b_c_start, 1);
        x3 = b_c_key[127:0] ^ b_c_key[255:128] ^ b_c_key[383:256];
        chk("d3 shares xor", x3, k1);
        chk("d3 share1", b_c_key[255:128], 128'h13579bdf_2468ace0_fedcba98_76543210);
        chk("d3 share2", b_c_key[383:256], 128'h0badf00d_0badf00d_0badf00d_0badf00d);
        b_pt_valid = 1; b_c_pt_ready = 1;
        @(posedge clk); #1;
        chk("d3 blk0 nbytes", b_c_pt_nbytes, 16);
        chk("d3 pt_ready", b_pt_ready, 1);
        @(posedge clk); #1;
        chk("d3 blk1 nbytes", b_c_pt_nbytes, 16);
        chk("d3 blk1 valid", b_c_pt_valid, 1);
        @(posedge clk); #1;
        chk("d3 input exhausted", b_c_pt_valid, 0);
        b_pt_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
